rc4_ksa_engine: RTL and testbench

Parametrised RC4 key-scheduling engine. It runs the complete KSA over an external single-port synchronous S-box RAM: an optional identity fill, then N = 2**ADDR_W iterations of j update and swap. It sits between the top-level controller (start/finish handshake) and the S-array memory. It replaces the single-step j calculator with a self-sequencing, key-length-generic block.

---
 rtl/rc4_pkg.sv | 27 ++
 rtl/rc4_key_select.sv | 26 ++
 rtl/rc4_ksa_engine.sv | 140 ++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types, defaults and key helper for the RC4 KSA engine
// Purpose: FSM state encoding, default parameters, and the bit-offset helper
//          that maps a key byte index onto the packed secret_key vector.
// Ports:   none (package).
package rc4_pkg;

  localparam int DEF_KEY_BYTES = 3;
  localparam int DEF_ADDR_W    = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL,
    ST_RD_I,
    ST_LD_I,
    ST_RD_J,
    ST_LD_J,
    ST_WR_I,
    ST_WR_J,
    ST_DONE
  } state_t;

  // Byte 0 is the most significant byte of the packed key.
  function automatic int key_byte_lsb(input int key_bytes, input int idx);
    return 8 * (key_bytes - 1 - idx);
  endfunction

endpackage

// File: rtl/rc4_key_select.sv
// rtl/rc4_key_select.sv - combinational KEY_BYTES-way key byte multiplexer
// Purpose: returns key byte i_kidx of the packed secret key.
// Ports:   i_key  - packed key, byte 0 in the top byte
//          i_kidx - byte index, 0..KEY_BYTES-1
//          o_byte - selected key byte
module rc4_key_select
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = DEF_KEY_BYTES,
  parameter int KIDX_W    = 1
) (
  input  logic [8*KEY_BYTES-1:0] i_key,
  input  logic [KIDX_W-1:0]      i_kidx,
  output logic [7:0]             o_byte
);

  always_comb begin
    o_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (i_kidx == KIDX_W'(b)) begin
        o_byte = i_key[key_byte_lsb(KEY_BYTES, b) +: 8];
      end
    end
  end

endmodule

// File: rtl/rc4_ksa_engine.sv
// rtl/rc4_ksa_engine.sv - self-sequencing RC4 key-scheduling engine
// Purpose: drives an external single-port synchronous S-box RAM through an
//          optional identity fill followed by the full KSA (N iterations of
//          j update and swap, 6 cycles each).
// Ports:   clk, rst_n        - clock, asynchronous active-low reset
//          start, init_en    - run request (level) and fill enable
//          secret_key        - key, byte 0 in the top byte
//          q                 - RAM read data, one cycle after address
//          address/data/wren - RAM address, write data, write enable
//          busy, finish      - run in progress / run complete
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = DEF_KEY_BYTES,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   init_en,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [ADDR_W-1:0]      q,
  output logic [ADDR_W-1:0]      address,
  output logic [ADDR_W-1:0]      data,
  output logic                   wren,
  output logic                   busy,
  output logic                   finish
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_i;
  logic [ADDR_W-1:0]   r_j;
  logic [ADDR_W-1:0]   r_si;
  logic [ADDR_W-1:0]   r_sj;
  logic [KIDX_W-1:0]   r_kidx;
  logic [7:0]          w_key_byte;
  logic [ADDR_W-1:0]   w_key_ext;

  rc4_key_select #(
    .KEY_BYTES (KEY_BYTES),
    .KIDX_W    (KIDX_W)
  ) u_key_select (
    .i_key  (secret_key),
    .i_kidx (r_kidx),
    .o_byte (w_key_byte)
  );

  // Truncates (or zero-extends) the key byte to the S-box data width.
  assign w_key_ext = ADDR_W'(w_key_byte);

  // Next state and RAM-side outputs; everything here decodes from state and
  // registers only, so q never reaches an output combinationally.
  always_comb begin
    w_state_nxt = r_state;
    address     = '0;
    data        = '0;
    wren        = 1'b0;
    busy        = 1'b1;
    finish      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = init_en ? ST_FILL : ST_RD_I;
      end
      ST_FILL: begin
        address = r_i;
        data    = r_i;
        wren    = 1'b1;
        if (&r_i) w_state_nxt = ST_RD_I;
      end
      ST_RD_I: begin
        address     = r_i;
        w_state_nxt = ST_LD_I;
      end
      ST_LD_I: w_state_nxt = ST_RD_J;
      ST_RD_J: begin
        address     = r_j;
        w_state_nxt = ST_LD_J;
      end
      ST_LD_J: w_state_nxt = ST_WR_I;
      ST_WR_I: begin
        address     = r_i;
        data        = r_sj;
        wren        = 1'b1;
        w_state_nxt = ST_WR_J;
      end
      // When i == j this rewrites the original S[i], which is the right result.
      ST_WR_J: begin
        address     = r_j;
        data        = r_si;
        wren        = 1'b1;
        w_state_nxt = (&r_i) ? ST_DONE : ST_RD_I;
      end
      ST_DONE: begin
        busy   = 1'b0;
        finish = 1'b1;
        // Requires start to drop before another run can begin.
        if (!start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_kidx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_i    <= '0;
            r_j    <= '0;
            r_kidx <= '0;
          end
        end
        // i wraps to 0 after N-1, ready for the KSA loop.
        ST_FILL: r_i <= r_i + 1'b1;
        ST_LD_I: begin
          r_si   <= q;
          r_j    <= r_j + q + w_key_ext;
          r_kidx <= (r_kidx == KIDX_LAST) ? '0 : r_kidx + 1'b1;
        end
        ST_LD_J: r_sj <= q;
        ST_WR_J: r_i  <= r_i + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// tb/tb_rc4_ksa_engine.sv - directed self-checking bench for rc4_ksa_engine
module tb_rc4_ksa_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        init_en = 1'b1;
  logic        init_en_c = 1'b0;
  logic        preload_c = 1'b0;

  // Instance A: defaults (KEY_BYTES=3, ADDR_W=8)
  logic [23:0] key_a = 24'h010203;
  logic [7:0]  q_a, addr_a, data_a;
  logic        wren_a, busy_a, finish_a;
  logic [7:0]  mem_a [256];

  // Instance B: KEY_BYTES=5, ADDR_W=8
  logic [39:0] key_b = 40'h0102030405;
  logic [7:0]  q_b, addr_b, data_b;
  logic        wren_b, busy_b, finish_b;
  logic [7:0]  mem_b [256];

  // Instance C: KEY_BYTES=1, ADDR_W=4, no fill over preloaded identity
  logic [7:0]  key_c = 8'hA7;
  logic [3:0]  q_c, addr_c, data_c;
  logic        wren_c, busy_c, finish_c;
  logic [3:0]  mem_c [16];

  int n_checks = 0;
  int n_fail = 0;
  int gold [256];
  int fin_a, fin_b, fin_c, wr_fill, wr_tot, fin_low;

  always #5 clk = ~clk;

  rc4_ksa_engine #(.KEY_BYTES(3), .ADDR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .init_en(init_en),
    .secret_key(key_a), .q(q_a), .address(addr_a), .data(data_a),
    .wren(wren_a), .busy(busy_a), .finish(finish_a));

  rc4_ksa_engine #(.KEY_BYTES(5), .ADDR_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .init_en(init_en),
    .secret_key(key_b), .q(q_b), .address(addr_b), .data(data_b),
    .wren(wren_b), .busy(busy_b), .finish(finish_b));

  rc4_ksa_engine #(.KEY_BYTES(1), .ADDR_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .init_en(init_en_c),
    .secret_key(key_c), .q(q_c), .address(addr_c), .data(data_c),
    .wren(wren_c), .busy(busy_c), .finish(finish_c));

  always @(posedge clk) begin
    if (wren_a) mem_a[addr_a] <= data_a;
    q_a <= mem_a[addr_a];
  end

  always @(posedge clk) begin
    if (wren_b) mem_b[addr_b] <= data_b;
    q_b <= mem_b[addr_b];
  end

  always @(posedge clk) begin
    if (preload_c) begin
      for (int k = 0; k < 16; k++) mem_c[k] <= 4'(k);
    end else if (wren_c) begin
      mem_c[addr_c] <= data_c;
    end
    q_c <= mem_c[addr_c];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Software KSA over an identity-initialised S of n entries.
  task automatic make_gold(input int n, input int klen, input logic [39:0] key);
    int j, t;
    logic [7:0] kb;
    for (int k = 0; k < n; k++) gold[k] = k;
    j = 0;
    for (int i = 0; i < n; i++) begin
      kb = key[8*(klen-1-(i%klen)) +: 8];
      j = (j + gold[i] + int'(kb)) % n;
      t = gold[i]; gold[i] = gold[j]; gold[j] = t;
    end
  endtask

  // Starts a run (edge 0) and watches up to max_e edges. Asserts reset at
  // edge abort_e; early=1 adds the fill and first-iteration checks on A.
  task automatic run(input bit hold, input bit early, input int max_e, input int abort_e);
    int bad;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    fin_a = -1; fin_b = -1; fin_c = -1;
    wr_fill = 0; wr_tot = 0; fin_low = 0;
    for (int e = 0; e <= max_e; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
      end
      if (wren_a) begin
        wr_tot++;
        if (e < 256) wr_fill++;
      end
      if (fin_a >= 0 && !finish_a) fin_low++;
      if (finish_a && fin_a < 0) fin_a = e;
      if (finish_b && fin_b < 0) fin_b = e;
      if (finish_c && fin_c < 0) fin_c = e;
      if (e == 0) check("busy_after_start", {busy_a, finish_a}, 2'b10);
      if (early && e == 256) begin
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem_a[k] !== 8'(k)) bad++;
        check("fill_identity_mismatches", bad, 0);
        check("fill_wren_count", wr_fill, 256);
      end
      if (early && e == 262) check("iter0_s0_s1", {mem_a[0], mem_a[1]}, 16'h0100);
      if (early && e == 268) check("iter1_s1_s3", {mem_a[1], mem_a[3]}, 16'h0300);
      if (e == abort_e) begin
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {wren_a, finish_a, busy_a, addr_a, data_a}, 19'h0);
        break;
      end
    end
  endtask

  initial begin
    int bad;
    // Reset state
    preload_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a_outputs", {wren_a, finish_a, busy_a, addr_a, data_a}, 19'h0);
    check("reset_c_outputs", {wren_c, finish_c, busy_c, addr_c, data_c}, 11'h0);
    @(negedge clk);
    preload_c = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", {busy_a, finish_a, wren_a}, 3'b000);

    // Run 1: fill + KSA on A/B, 16-entry KSA on C, start pulsed
    run(1'b0, 1'b1, 1850, -1);
    check("finish_edge_a_fill", fin_a, 1792);
    check("finish_edge_b_fill", fin_b, 1792);
    check("finish_edge_c_n16", fin_c, 96);
    make_gold(256, 3, 40'h0000010203);
    bad = 0;
    for (int k = 0; k < 256; k++) if (int'(mem_a[k]) != gold[k]) bad++;
    check("gold_a_010203", bad, 0);
    make_gold(256, 5, 40'h0102030405);
    bad = 0;
    for (int k = 0; k < 256; k++) if (int'(mem_b[k]) != gold[k]) bad++;
    check("gold_b_0102030405", bad, 0);
    make_gold(16, 1, 40'h00000000A7);
    bad = 0;
    for (int k = 0; k < 16; k++) if (int'(mem_c[k]) != gold[k]) bad++;
    check("gold_c_a7_n16", bad, 0);
    check("idle_after_pulse", {busy_a, finish_a}, 2'b00);

    // Run 2: start held high 2000 edges -> exactly one run, finish stays high
    key_a = 24'h000249;
    run(1'b1, 1'b0, 2000, -1);
    check("held_finish_edge", fin_a, 1792);
    check("held_total_writes", wr_tot, 768);
    check("held_finish_drops", fin_low, 0);
    make_gold(256, 3, 40'h0000000249);
    bad = 0;
    for (int k = 0; k < 256; k++) if (int'(mem_a[k]) != gold[k]) bad++;
    check("gold_a_000249", bad, 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("drop_start_idle", {busy_a, finish_a}, 2'b00);

    // Run 3: reset at edge 700, then a clean restart
    run(1'b0, 1'b0, 2000, 700);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 1'b0, 1850, -1);
    check("restart_finish_edge", fin_a, 1792);
    bad = 0;
    for (int k = 0; k < 256; k++) if (int'(mem_a[k]) != gold[k]) bad++;
    check("restart_gold_a_000249", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
